// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding,
// operation select encoding and the default iteration count.
package muldiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_EXC   = 3'd5
    } state_t;

    // Same encoding as the datapath's mult/div select.
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int unsigned CYCLES_DEFAULT = 32;

endpackage : muldiv_pkg

// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the control unit, the sequencer and the
// mult/div unit with its Hi/Lo loads.
interface muldiv_sequencer_if;

    logic req;
    logic op;
    logic divisor_zero;
    logic abort;
    logic unit_start;
    logic unit_op;
    logic load_hi;
    logic load_lo;
    logic busy;
    logic done;
    logic div_zero_exc;

    // The control side drives requests and consumes the strobes.
    modport master (
        output req, op, divisor_zero, abort,
        input  unit_start, unit_op, load_hi, load_lo, busy, done, div_zero_exc
    );

    // The sequencer itself.
    modport slave (
        input  req, op, divisor_zero, abort,
        output unit_start, unit_op, load_hi, load_lo, busy, done, div_zero_exc
    );

endinterface : muldiv_sequencer_if

// File: rtl/muldiv_sequencer.sv
// Moore FSM that starts the iterative mult/div unit, waits out its fixed
// iteration count, then strobes the Hi/Lo loads and done; traps divide-by-zero.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned CYCLES = CYCLES_DEFAULT  // legal range 1..255
) (
    input  logic               i_clk,
    input  logic               i_reset,
    muldiv_sequencer_if.slave  bus
);

    localparam int unsigned         CNT_W    = $clog2(CYCLES + 1);
    localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(CYCLES - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_unit_op;

    state_t             w_next_state;
    logic               w_accept;
    logic               w_unit_start;
    logic               w_load;
    logic               w_busy;
    logic               w_done;
    logic               w_div_zero_exc;

    // Next state and output decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        w_next_state   = r_state;
        w_accept       = 1'b0;
        w_unit_start   = 1'b0;
        w_load         = 1'b0;
        w_busy         = (r_state != ST_IDLE);
        w_done         = 1'b0;
        w_div_zero_exc = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.req) begin
                    if (bus.op == OP_DIV && bus.divisor_zero) begin
                        w_next_state = ST_EXC;
                    end else begin
                        w_next_state = ST_START;
                        w_accept     = 1'b1;
                    end
                end
            end
            ST_START: begin
                w_unit_start = 1'b1;
                w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (r_cnt == '0) w_next_state = ST_WRITE;
            end
            ST_WRITE: begin
                w_load       = 1'b1;
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            ST_EXC: begin
                w_div_zero_exc = 1'b1;
                w_next_state   = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase

        // Abort cuts the operation short but never the exception strobe.
        if (bus.abort && r_state != ST_IDLE && r_state != ST_EXC) begin
            w_next_state = ST_IDLE;
        end
    end

    // State, iteration counter and latched operation select.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_unit_op <= OP_MULT;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= w_next_state;
            if (w_accept) r_unit_op <= bus.op;
            if (r_state == ST_START) begin
                r_cnt <= CNT_LOAD;
            end else if (r_state == ST_RUN && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign bus.unit_start   = w_unit_start;
    assign bus.unit_op      = r_unit_op;
    assign bus.load_hi      = w_load;
    assign bus.load_lo      = w_load;
    assign bus.busy         = w_busy;
    assign bus.done         = w_done;
    assign bus.div_zero_exc = w_div_zero_exc;

endmodule : muldiv_sequencer

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with CYCLES=32 and CYCLES=1 instances;
// expected strobes are derived cycle by cycle from the request edge.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;   // 0: CYCLES=32 instance, 1: CYCLES=1 instance
    logic req = 1'b0;
    logic op  = 1'b0;
    logic dz  = 1'b0;
    logic ab  = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    muldiv_sequencer_if if32 ();
    muldiv_sequencer_if if1 ();

    assign if32.req          = req & ~sel;
    assign if32.op           = op;
    assign if32.divisor_zero = dz;
    assign if32.abort        = ab & ~sel;
    assign if1.req           = req & sel;
    assign if1.op            = op;
    assign if1.divisor_zero  = dz;
    assign if1.abort         = ab & sel;

    muldiv_sequencer #(.CYCLES(32)) dut32 (.i_clk(clk), .i_reset(rst), .bus(if32.slave));
    muldiv_sequencer #(.CYCLES(1))  dut1  (.i_clk(clk), .i_reset(rst), .bus(if1.slave));

    // {busy, unit_start, load_hi, load_lo, done, div_zero_exc, unit_op}
    logic [6:0] obs32, obs1, obs;
    assign obs32 = {if32.busy, if32.unit_start, if32.load_hi, if32.load_lo,
                    if32.done, if32.div_zero_exc, if32.unit_op};
    assign obs1  = {if1.busy, if1.unit_start, if1.load_hi, if1.load_lo,
                    if1.done, if1.div_zero_exc, if1.unit_op};
    assign obs   = sel ? obs1 : obs32;

    function automatic logic [6:0] ev(logic busy, logic start, logic load,
                                      logic done, logic exc, logic uop);
        return {busy, start, load, load, done, exc, uop};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_checks++;
        assert (o === e) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Issues one request and checks every cycle from k+1 through k+last.
    task automatic run_op(input string name, input logic s, input logic o, input int c,
                          input int abort_at, input bit extra, input int last,
                          output int done_cyc);
        logic aborted;
        done_cyc = -1;
        sel = s; op = o; dz = 1'b0; req = 1'b1;
        tick();
        req = 1'b0;
        for (int i = 1; i <= last; i++) begin
            if (i > 1) tick();
            aborted = (abort_at != 0) && (i > abort_at);
            check($sformatf("%s i=%0d", name, i), obs,
                  ev(!aborted && i <= c + 3, !aborted && i == 1, !aborted && i == c + 2,
                     !aborted && i == c + 3, 1'b0, o));
            if (obs[2]) done_cyc = cyc;
            ab  = (i == abort_at);
            req = extra && (i == 3 || i == c + 1 || i == c + 2 || i == c + 3);
            op  = extra ? ~o : o;
            dz  = 1'b0;
        end
        ab = 1'b0; req = 1'b0; op = o;
    endtask

    int d1, d2, dummy;

    initial begin
        // Reset held two cycles, then released.
        rst = 1'b1;
        tick();
        check("reset32", obs32, 7'd0);
        check("reset1", obs1, 7'd0);
        tick();
        rst = 1'b0;
        tick();
        check("idle32", obs32, 7'd0);
        check("idle1", obs1, 7'd0);

        // MULT, full latency and strobe widths.
        run_op("mult", 1'b0, OP_MULT, 32, 0, 1'b0, 37, d1);
        check("mult_done_seen", (d1 >= 0), 1);

        // Divide by zero: one-cycle exception, unit_op left at MULT.
        sel = 1'b0; op = OP_DIV; dz = 1'b1; req = 1'b1;
        tick();
        req = 1'b0; dz = 1'b0; op = OP_MULT;
        check("dz_exc", obs, ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, OP_MULT));
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("dz_after i=%0d", i), obs, 7'd0);
        end

        // DIV with extra requests during RUN, WRITE and DONE, all ignored.
        run_op("div_extra", 1'b0, OP_DIV, 32, 0, 1'b1, 38, d1);

        // Abort in RUN cycle 20, then a new request two cycles later.
        run_op("abort", 1'b0, OP_MULT, 32, 21, 1'b0, 23, dummy);
        check("abort_no_done", dummy, -1);
        run_op("after_abort", 1'b0, OP_MULT, 32, 0, 1'b0, 36, dummy);

        // Reset during RUN: IDLE next edge, unit_op cleared, nothing follows.
        sel = 1'b0; op = OP_DIV; dz = 1'b0; req = 1'b1;
        tick();
        req = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("pre_reset_run", obs, ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OP_DIV));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_reset", obs, 7'd0);
        for (int i = 0; i < 32; i++) begin
            tick();
            check($sformatf("post_reset i=%0d", i), obs, 7'd0);
        end

        // Back-to-back, CYCLES=32.
        run_op("b2b32_a", 1'b0, OP_DIV, 32, 0, 1'b0, 36, d1);
        run_op("b2b32_b", 1'b0, OP_MULT, 32, 0, 1'b0, 37, d2);
        check("b2b32_gap", d2 - d1, 36);

        // Back-to-back, CYCLES=1: done four cycles after the request edge.
        run_op("b2b1_a", 1'b1, OP_MULT, 1, 0, 1'b0, 5, d1);
        run_op("b2b1_b", 1'b1, OP_DIV, 1, 0, 1'b0, 6, d2);
        check("b2b1_gap", d2 - d1, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_muldiv_sequencer
